sd_init_seq: RTL and testbench

SD_INIT_SEQ -- requirements
Module: sd_init_seq

---
 rtl/sd_init_seq.sv | 199 +++++++++++++++++++
 tb/tb_sd_init_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_seq.sv
// SD card initialisation sequencer: CMD0, optional CMD8, then CMD55/ACMD41 until the card reports ready.
// Define SD_INIT_CMD8_EN to include the CMD8 interface-condition step.
module sd_init_seq #(
    parameter int MAX_RETRY = 255,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    output logic [47:0] cmd,
    output logic        cmd_start,
    input  logic        resp_valid,
    input  logic [7:0]  resp,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [2:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [1:0] {
        STEP_CMD0   = 2'd0,
`ifdef SD_INIT_CMD8_EN
        STEP_CMD8   = 2'd1,
`endif
        STEP_CMD55  = 2'd2,
        STEP_ACMD41 = 2'd3
    } step_t;

    localparam logic [47:0] FRAME_CMD0   = 48'h400000000095;
`ifdef SD_INIT_CMD8_EN
    localparam logic [47:0] FRAME_CMD8   = 48'h48000001AA87;
`endif
    localparam logic [47:0] FRAME_CMD55  = 48'h770000000065;
    localparam logic [47:0] FRAME_ACMD41 = 48'h694000000077;

    localparam logic [2:0] ERR_CMD0    = 3'd1;
`ifdef SD_INIT_CMD8_EN
    localparam logic [2:0] ERR_CMD8    = 3'd2;
`endif
    localparam logic [2:0] ERR_CMD55   = 3'd3;
    localparam logic [2:0] ERR_RETRY   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT);
    localparam logic [7:0]  RETRY_LIMIT  = 8'(MAX_RETRY);

    state_t      state, state_next;
    step_t       step, step_next;
    logic [7:0]  retry, retry_next;
    logic [15:0] timer, timer_next;
    logic [2:0]  code, code_next;

    logic [7:0]  retry_inc;
    logic        retry_spent;

    // Saturating increment; a full counter counts as exhausted so nothing ever wraps.
    assign retry_inc   = (retry == 8'hFF) ? 8'hFF : retry + 8'd1;
    assign retry_spent = (retry_inc == RETRY_LIMIT) || (retry == 8'hFF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            step  <= STEP_CMD0;
            retry <= 8'd0;
            timer <= 16'd0;
            code  <= 3'd0;
        end else begin
            state <= state_next;
            step  <= step_next;
            retry <= retry_next;
            timer <= timer_next;
            code  <= code_next;
        end
    end

    always_comb begin
        state_next = state;
        step_next  = step;
        retry_next = retry;
        timer_next = timer;
        code_next  = code;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (go) begin
                    state_next = S_SEND;
                    step_next  = STEP_CMD0;
                    retry_next = 8'd0;
                    code_next  = 3'd0;
                end
            end
            S_SEND: begin
                timer_next = TIMEOUT_LOAD;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A response arriving on the last timer cycle still counts.
                if (resp_valid) begin
                    state_next = S_SEND;
                    case (step)
                        STEP_CMD0: begin
                            if (resp == 8'h01) begin
`ifdef SD_INIT_CMD8_EN
                                step_next = STEP_CMD8;
`else
                                step_next = STEP_CMD55;
`endif
                            end else begin
                                state_next = S_ERROR;
                                code_next  = ERR_CMD0;
                            end
                        end
`ifdef SD_INIT_CMD8_EN
                        STEP_CMD8: begin
                            if (resp == 8'h01) begin
                                step_next = STEP_CMD55;
                            end else begin
                                state_next = S_ERROR;
                                code_next  = ERR_CMD8;
                            end
                        end
`endif
                        STEP_CMD55: begin
                            if (resp == 8'h00 || resp == 8'h01) begin
                                step_next = STEP_ACMD41;
                            end else begin
                                state_next = S_ERROR;
                                code_next  = ERR_CMD55;
                            end
                        end
                        STEP_ACMD41: begin
                            if (resp == 8'h00) begin
                                state_next = S_DONE;
                            end else if (resp == 8'h01) begin
                                retry_next = retry_inc;
                                if (retry_spent) begin
                                    state_next = S_ERROR;
                                    code_next  = ERR_RETRY;
                                end else begin
                                    step_next = STEP_CMD55;
                                end
                            end else begin
                                state_next = S_ERROR;
                                code_next  = ERR_CMD55;
                            end
                        end
                        default: state_next = S_IDLE;
                    endcase
                end else if (timer <= 16'd1) begin
                    timer_next = 16'd0;
                    state_next = S_ERROR;
                    code_next  = ERR_TIMEOUT;
                end else begin
                    timer_next = timer - 16'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The frame is a pure function of the step, which only changes when leaving WAIT.
    always_comb begin
        cmd       = 48'd0;
        cmd_start = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        err_code  = 3'd0;
        case (state)
            S_SEND, S_WAIT: begin
                busy      = 1'b1;
                cmd_start = (state == S_SEND);
                case (step)
                    STEP_CMD0:   cmd = FRAME_CMD0;
`ifdef SD_INIT_CMD8_EN
                    STEP_CMD8:   cmd = FRAME_CMD8;
`endif
                    STEP_CMD55:  cmd = FRAME_CMD55;
                    STEP_ACMD41: cmd = FRAME_ACMD41;
                    default:     cmd = 48'd0;
                endcase
            end
            S_DONE: done = 1'b1;
            S_ERROR: begin
                err      = 1'b1;
                err_code = code;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sd_init_seq.sv
// Scoreboard bench for sd_init_seq: expected frames and final status are queued as stimulus is
// issued, and a negedge monitor checks them against cmd_start and the done/err rising edge.
module tb_sd_init_seq;

    localparam logic [47:0] F_CMD0   = 48'h400000000095;
    localparam logic [47:0] F_CMD8   = 48'h48000001AA87;
    localparam logic [47:0] F_CMD55  = 48'h770000000065;
    localparam logic [47:0] F_ACMD41 = 48'h694000000077;

    localparam logic [4:0] ST_DONE = 5'b10_000;

    logic        clk;
    logic        rst;
    logic        go;
    logic [47:0] cmd;
    logic        cmd_start;
    logic        resp_valid;
    logic [7:0]  resp;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  err_code;

    logic [7:0]  rsp_tab [0:15];
    int          n_rsp;
    logic [47:0] exp_cmd [$];
    logic [4:0]  exp_stat [$];
    logic [47:0] e_cmd;
    logic [4:0]  e_stat;
    logic [47:0] last_cmd;
    logic        fin_prev;
    int          vectors;
    int          miscompares;

    sd_init_seq #(
        .MAX_RETRY (3),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .cmd        (cmd),
        .cmd_start  (cmd_start),
        .resp_valid (resp_valid),
        .resp       (resp),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: pops expected frames on cmd_start and expected status when done/err rises.
    always @(negedge clk) begin
        if (cmd_start) begin
            vectors++;
            if (exp_cmd.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_cmd_start: cmd=%h, none expected", cmd);
            end else begin
                e_cmd = exp_cmd.pop_front();
                if (cmd !== e_cmd) begin
                    miscompares++;
                    $display("[TB] FAIL cmd_frame: got %h, expected %h", cmd, e_cmd);
                end
            end
        end else if (busy) begin
            vectors++;
            if (cmd !== last_cmd) begin
                miscompares++;
                $display("[TB] FAIL cmd_stable: got %h, expected %h", cmd, last_cmd);
            end
        end
        if ((done || err) && !fin_prev) begin
            vectors++;
            if (exp_stat.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_status: got %b, none expected", {done, err, err_code});
            end else begin
                e_stat = exp_stat.pop_front();
                if ({done, err, err_code} !== e_stat) begin
                    miscompares++;
                    $display("[TB] FAIL final_status: got %b, expected %b", {done, err, err_code}, e_stat);
                end
            end
        end
        last_cmd <= cmd;
        fin_prev <= done || err;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic addStep(input logic [47:0] frame, input logic [7:0] r);
        exp_cmd.push_back(frame);
        rsp_tab[n_rsp] = r;
        n_rsp++;
    endtask

    task automatic expectInit();
        addStep(F_CMD0, 8'h01);
`ifdef SD_INIT_CMD8_EN
        addStep(F_CMD8, 8'h01);
`endif
    endtask

    task automatic pulseGo();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    task automatic waitStart(output int cycles);
        cycles = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cmd_start) begin
                cycles = k;
                break;
            end
        end
    endtask

    // Starts a sequence and answers each queued step after 'delay' extra WAIT cycles.
    task automatic applyStimulus(input int delay, input bit poke_go);
        int lat;
        pulseGo();
        for (int i = 0; i < n_rsp; i++) begin
            waitStart(lat);
            checkOutput("start_latency", 64'(lat), 64'd1);
            if (lat < 0) break;
            @(posedge clk); #1;
            if (poke_go && i == 0) begin
                go = 1'b1;
                @(posedge clk); #1 go = 1'b0;
            end
            repeat (delay) @(posedge clk);
            #1;
            resp       = rsp_tab[i];
            resp_valid = 1'b1;
            @(posedge clk); #1;
            resp_valid = 1'b0;
            resp       = 8'hFF;
        end
        n_rsp = 0;
    endtask

    task automatic drainCheck();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("cmd_queue_empty", 64'(exp_cmd.size()), 64'd0);
        checkOutput("stat_queue_empty", 64'(exp_stat.size()), 64'd0);
    endtask

    initial begin
        int lat;
        rst = 1'b0; go = 1'b0; resp_valid = 1'b0; resp = 8'h00;
        n_rsp = 0; vectors = 0; miscompares = 0;
        fin_prev = 1'b0; last_cmd = 48'd0;

        $display("[TB] reset state");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_cmd", 64'(cmd), 64'd0);
        checkOutput("rst_cmd_start", 64'(cmd_start), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        checkOutput("rst_err_code", 64'(err_code), 64'd0);
        rst = 1'b1;

        $display("[TB] happy path");
        expectInit();
        addStep(F_CMD55, 8'h01);
        addStep(F_ACMD41, 8'h00);
        exp_stat.push_back(ST_DONE);
        applyStimulus(2, 1'b0);
        checkOutput("happy_done", 64'(done), 64'd1);
        checkOutput("happy_busy", 64'(busy), 64'd0);
        checkOutput("happy_err_code", 64'(err_code), 64'd0);
        @(posedge clk); #1 resp = 8'h05; resp_valid = 1'b1;
        @(posedge clk); #1 resp_valid = 1'b0;
        checkOutput("ignored_resp_done", 64'(done), 64'd1);
        checkOutput("ignored_resp_err", 64'(err), 64'd0);
        drainCheck();

        $display("[TB] retry then ready, go poked while busy");
        expectInit();
        addStep(F_CMD55, 8'h00);
        addStep(F_ACMD41, 8'h01);
        addStep(F_CMD55, 8'h01);
        addStep(F_ACMD41, 8'h01);
        addStep(F_CMD55, 8'h00);
        addStep(F_ACMD41, 8'h00);
        exp_stat.push_back(ST_DONE);
        applyStimulus(1, 1'b1);
        checkOutput("retry_done", 64'(done), 64'd1);
        drainCheck();

        $display("[TB] retries exhausted");
        expectInit();
        addStep(F_CMD55, 8'h01);
        addStep(F_ACMD41, 8'h01);
        addStep(F_CMD55, 8'h01);
        addStep(F_ACMD41, 8'h01);
        addStep(F_CMD55, 8'h01);
        addStep(F_ACMD41, 8'h01);
        exp_stat.push_back({2'b01, 3'd4});
        applyStimulus(0, 1'b0);
        checkOutput("exhaust_err_code", 64'(err_code), 64'd4);
        drainCheck();

        $display("[TB] bad CMD0 response");
        addStep(F_CMD0, 8'h05);
        exp_stat.push_back({2'b01, 3'd1});
        applyStimulus(3, 1'b0);
        checkOutput("bad_cmd0_err", 64'(err), 64'd1);
        checkOutput("bad_cmd0_code", 64'(err_code), 64'd1);
        checkOutput("bad_cmd0_busy", 64'(busy), 64'd0);
        drainCheck();

`ifdef SD_INIT_CMD8_EN
        $display("[TB] bad CMD8 response");
        addStep(F_CMD0, 8'h01);
        addStep(F_CMD8, 8'h05);
        exp_stat.push_back({2'b01, 3'd2});
        applyStimulus(1, 1'b0);
        checkOutput("bad_cmd8_code", 64'(err_code), 64'd2);
        drainCheck();
`endif

        $display("[TB] bad CMD55 and bad ACMD41 responses");
        expectInit();
        addStep(F_CMD55, 8'h04);
        exp_stat.push_back({2'b01, 3'd3});
        applyStimulus(1, 1'b0);
        checkOutput("bad_cmd55_code", 64'(err_code), 64'd3);
        drainCheck();
        expectInit();
        addStep(F_CMD55, 8'h01);
        addStep(F_ACMD41, 8'h02);
        exp_stat.push_back({2'b01, 3'd3});
        applyStimulus(1, 1'b0);
        checkOutput("bad_acmd41_code", 64'(err_code), 64'd3);
        drainCheck();

        $display("[TB] timeout after CMD0");
        exp_cmd.push_back(F_CMD0);
        exp_stat.push_back({2'b01, 3'd5});
        pulseGo();
        waitStart(lat);
        checkOutput("timeout_start", 64'(lat), 64'd1);
        repeat (16) @(posedge clk);
        #1;
        checkOutput("timeout_not_yet", 64'(err), 64'd0);
        @(posedge clk); #1;
        checkOutput("timeout_err", 64'(err), 64'd1);
        checkOutput("timeout_code", 64'(err_code), 64'd5);
        drainCheck();

        $display("[TB] response on the last timer cycle");
        expectInit();
        addStep(F_CMD55, 8'h01);
        addStep(F_ACMD41, 8'h00);
        exp_stat.push_back(ST_DONE);
        applyStimulus(15, 1'b0);
        checkOutput("late_resp_done", 64'(done), 64'd1);
        drainCheck();

        $display("[TB] reset during WAIT");
        exp_cmd.push_back(F_CMD0);
        pulseGo();
        waitStart(lat);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        checkOutput("midrst_cmd", 64'(cmd), 64'd0);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_cmd_start", 64'(cmd_start), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("midrst_idle_busy", 64'(busy), 64'd0);
        drainCheck();
        addStep(F_CMD0, 8'h01);
`ifdef SD_INIT_CMD8_EN
        addStep(F_CMD8, 8'h01);
`endif
        addStep(F_CMD55, 8'h00);
        addStep(F_ACMD41, 8'h00);
        exp_stat.push_back(ST_DONE);
        applyStimulus(2, 1'b0);
        checkOutput("after_rst_done", 64'(done), 64'd1);
        drainCheck();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
